// File: rtl/fixed_point_resizer.sv
`default_nettype none
// ============================================================================
// fixed_point_resizer : pipelined signed fixed-point format converter with
// selectable rounding and saturate/wrap; FXP_RESIZE_OVF_CNT_EN adds ovf_count.
// Revision 1.0
// ============================================================================
module fixed_point_resizer #(
  parameter int DIN_WIDTH  = 32,
  parameter int DIN_FRAC   = 30,
  parameter int DOUT_WIDTH = 16,
  parameter int DOUT_FRAC  = 15,
  parameter int NUM_CH     = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DIN_WIDTH-1:0]  din,
  input  logic [1:0]                   round_mode,
  input  logic                         sat_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH*DOUT_WIDTH-1:0] dout,
  output logic [NUM_CH-1:0]            ovf,
  input  logic                         clr_sticky,
  output logic                         ovf_sticky
`ifdef FXP_RESIZE_OVF_CNT_EN
  ,
  output logic [15:0]                  ovf_count
`endif
);

  localparam int SH  = DIN_FRAC - DOUT_FRAC;
  // Rounded-value width: one extra bit absorbs the rounding carry.
  localparam int RW  = (SH > 0) ? (DIN_WIDTH - SH + 1) : (DIN_WIDTH - SH);
  localparam int LSH = (SH < 0) ? -SH : 0;

  logic                         w_adv;
  logic                         w_set;
  logic [NUM_CH*RW-1:0]         w_rnd;
  logic [NUM_CH*DOUT_WIDTH-1:0] w_dout;
  logic [NUM_CH-1:0]            w_ovf;
  logic [NUM_CH*RW-1:0]         r_rnd;
  logic                         r_s1_valid;
  logic                         r_s1_sat;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [DIN_WIDTH-1:0]  w_din;
    logic [RW-1:0]         w_v;
    logic [DOUT_WIDTH-1:0] w_o;

    assign w_din = din[k*DIN_WIDTH +: DIN_WIDTH];

    if (SH > 0) begin : g_round
      logic [RW-1:0] w_a;
      logic [SH-1:0] w_low;
      logic          w_half;
      logic          w_rest;
      logic          w_inc;

      assign w_a    = {w_din[DIN_WIDTH-1], w_din[DIN_WIDTH-1:SH]};
      assign w_half = w_din[SH-1];

      always_comb begin
        w_low       = w_din[SH-1:0];
        w_low[SH-1] = 1'b0;
      end
      assign w_rest = |w_low;

      // Convergent: ties (half set, rest clear) round toward the even value.
      always_comb begin
        case (round_mode)
          2'd1:    w_inc = w_half;
          2'd2:    w_inc = w_half & (w_rest | w_a[0]);
          default: w_inc = 1'b0;
        endcase
      end

      assign w_rnd[k*RW +: RW] = w_a + RW'(w_inc);
    end else begin : g_shift
      assign w_rnd[k*RW +: RW] = RW'($signed(w_din)) <<< LSH;
    end

    assign w_v = r_rnd[k*RW +: RW];

    if (RW > DOUT_WIDTH) begin : g_check
      logic w_over;
      // In range only when every bit above the output sign bit matches it.
      assign w_over = !((&w_v[RW-1:DOUT_WIDTH-1]) || !(|w_v[RW-1:DOUT_WIDTH-1]));

      always_comb begin
        if (w_over && r_s1_sat) begin
          w_o = w_v[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                          : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end else begin
          w_o = w_v[DOUT_WIDTH-1:0];
        end
      end
      assign w_ovf[k] = w_over;
    end else begin : g_fit
      assign w_o      = DOUT_WIDTH'($signed(w_v));
      assign w_ovf[k] = 1'b0;
    end

    assign w_dout[k*DOUT_WIDTH +: DOUT_WIDTH] = w_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sat   <= 1'b0;
      r_rnd      <= '0;
      out_valid  <= 1'b0;
      dout       <= '0;
      ovf        <= '0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_sat   <= sat_en;
      r_rnd      <= w_rnd;
      out_valid  <= r_s1_valid;
      if (r_s1_valid) begin
        dout <= w_dout;
        ovf  <= w_ovf;
      end
    end
  end

  assign w_set = w_adv && r_s1_valid && (|w_ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky <= 1'b0;
    end else if (w_set) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end

`ifdef FXP_RESIZE_OVF_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (clr_sticky) begin
      r_cnt <= 16'd0;
    end else if (w_set && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign ovf_count = r_cnt;
`endif

endmodule
`default_nettype wire
